// File: rtl/usrt_tx.sv
// usrt_tx: USRT serial transmitter, start bit, 8 data bits LSB first, optional parity, stop bit(s).
module usrt_tx #(
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic        i_Pclk,
    input  logic        i_Presetn,
    input  logic [7:0]  i_Data,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic        i_Parity,
    input  logic [13:0] i_Baud,
    output logic        o_Tx,
    output logic        o_Busy,
    output logic        o_Done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t      r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [13:0] r_period, r_bit_cnt;
    logic [14:0] r_stop_cnt, w_stop_last;
    logic [2:0]  r_bit_idx;
    logic        r_par_en, r_par_bit, r_tx, r_done;
    logic        w_accept, w_bit_end, w_stop_end, w_tx_nxt;
    assign o_Ready     = r_state == IDLE;
    assign o_Busy      = r_state != IDLE;
    assign o_Tx        = r_tx;
    assign o_Done      = r_done;
    assign w_accept    = i_Valid && o_Ready;
    assign w_bit_end   = r_bit_cnt == r_period - 14'd1;
    assign w_stop_last = (STOP_BITS == 2 ? {r_period, 1'b0} : {1'b0, r_period}) - 15'd1;
    assign w_stop_end  = r_stop_cnt == w_stop_last;
    assign w_shift_nxt = w_accept ? i_Data : (r_state == DATA && w_bit_end) ? r_shift >> 1 : r_shift;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_Valid) w_state_nxt = START;
            START:   if (w_bit_end) w_state_nxt = DATA;
            DATA:    if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = r_par_en ? PARITY : STOP;
            PARITY:  if (w_bit_end) w_state_nxt = STOP;
            STOP:    if (w_stop_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // o_Tx is registered, so it is driven from the state being entered
        w_tx_nxt = w_state_nxt == START  ? 1'b0 :
                   w_state_nxt == DATA   ? w_shift_nxt[0] :
                   w_state_nxt == PARITY ? r_par_bit : 1'b1;
    end
    always_ff @(posedge i_Pclk or negedge i_Presetn)
        if (!i_Presetn) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    always_ff @(posedge i_Pclk or negedge i_Presetn)
        if (!i_Presetn) begin
            r_shift    <= '0;
            r_period   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= r_state == STOP && w_stop_end;
            if (w_accept) begin
                r_par_en   <= i_Parity;
                r_par_bit  <= ^i_Data ^ PARITY_ODD;
                r_period   <= i_Baud == 14'd0 ? 14'd1 : i_Baud;
                r_bit_cnt  <= '0;
                r_bit_idx  <= '0;
                r_stop_cnt <= '0;
            end else if (r_state == STOP) begin
                r_stop_cnt <= w_stop_end ? '0 : r_stop_cnt + 15'd1;
            end else if (r_state != IDLE) begin
                r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + 14'd1;
                if (r_state == DATA && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
endmodule

// File: tb/tb_usrt_tx.sv
// tb_usrt_tx: random and directed frames on three usrt_tx variants, checked cycle by cycle
// against a per-instance queue of expected {tx, busy, done} built from the frame rules.
module tb_usrt_tx;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  data = 0;
    logic        par = 0;
    logic [13:0] baud = 0;
    logic [2:0]  v = 0, exp_rdy = 0, acc = 0;
    wire  [2:0]  tx, rdy, busy, done;
    logic [2:0]  exp_q [3][$];
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    // u0: even parity, 1 stop; u1: odd parity, 1 stop; u2: even parity, 2 stops
    usrt_tx #(.PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (.i_Pclk(clk), .i_Presetn(rst_n), .i_Data(data),
        .i_Valid(v[0]), .o_Ready(rdy[0]), .i_Parity(par), .i_Baud(baud), .o_Tx(tx[0]), .o_Busy(busy[0]), .o_Done(done[0]));
    usrt_tx #(.PARITY_ODD(1'b1), .STOP_BITS(1)) u1 (.i_Pclk(clk), .i_Presetn(rst_n), .i_Data(data),
        .i_Valid(v[1]), .o_Ready(rdy[1]), .i_Parity(par), .i_Baud(baud), .o_Tx(tx[1]), .o_Busy(busy[1]), .o_Done(done[1]));
    usrt_tx #(.PARITY_ODD(1'b0), .STOP_BITS(2)) u2 (.i_Pclk(clk), .i_Presetn(rst_n), .i_Data(data),
        .i_Valid(v[2]), .o_Ready(rdy[2]), .i_Parity(par), .i_Baud(baud), .o_Tx(tx[2]), .o_Busy(busy[2]), .o_Done(done[2]));

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(int k, logic [7:0] d, logic p_en, logic [13:0] b);
        int         p;
        logic [9:0] bits;
        p    = b == 0 ? 1 : int'(b);
        bits = {^d ^ (k == 1), d, 1'b0};
        for (int i = 0; i < 9 + int'(p_en); i++)
            for (int j = 0; j < p; j++) exp_q[k].push_back({bits[i], 2'b10});
        for (int j = 0; j < p * (k == 2 ? 2 : 1); j++) exp_q[k].push_back(3'b110);
        exp_q[k].push_back(3'b101);
    endfunction

    always @(posedge clk)
        for (int k = 0; k < 3; k++) begin
            acc[k] = rst_n && v[k] && exp_rdy[k];
            if (acc[k]) push_frame(k, data, par, baud);
        end

    always @(negedge clk) begin
        logic [2:0] e;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) exp_q[k].delete();
            if (exp_q[k].size() > 0) e = exp_q[k].pop_front();
            else e = 3'b100;
            exp_rdy[k] = !e[1];
            check($sformatf("dut%0d_t%0t", k, $time), {28'd0, tx[k], rdy[k], busy[k], done[k]},
                  {28'd0, e[2], !e[1], e[1], e[0]});
        end
    end

    task automatic wait_acc(int k);
        int n = 0;
        do begin @(negedge clk); n++; end while (!acc[k] && n < 500);
        if (!acc[k]) check("accept_timeout", 0, 1);
    endtask

    task automatic send(int k, logic [7:0] d, logic p_en, logic [13:0] b);
        data = d; par = p_en; baud = b; v[k] = 1'b1;
        wait_acc(k);
        v[k] = 1'b0;
    endtask

    task automatic wait_idle(int k);
        int n = 0;
        while (exp_q[k].size() > 0 && n < 2000) begin @(negedge clk); n++; end
        if (exp_q[k].size() > 0) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send(0, 8'hA5, 0, 4);  wait_idle(0);
        send(0, 8'hA5, 1, 4);  wait_idle(0);
        send(0, 8'h07, 1, 4);  wait_idle(0);
        send(1, 8'hA5, 1, 4);  wait_idle(1);
        send(1, 8'h07, 1, 4);  wait_idle(1);
        data = 8'h01; par = 0; baud = 2; v[0] = 1'b1;
        wait_acc(0);
        data = 8'h80;
        wait_acc(0);
        v[0] = 1'b0;
        wait_idle(0);
        send(0, 8'hC3, 0, 3);
        baud = 10; par = 1; data = 8'hFF;
        wait_idle(0);
        send(0, 8'h96, 1, 10); wait_idle(0);
        send(0, 8'h5A, 0, 4);
        repeat (8) @(negedge clk);
        #2 rst_n = 0;
        #1 for (int i = 0; i < 3; i++)
            check($sformatf("rst_async%0d", i), {28'd0, tx[i], rdy[i], busy[i], done[i]}, 32'hC);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        send(0, 8'h3C, 0, 4);  wait_idle(0);
        send(2, 8'h6E, 0, 0);  wait_idle(2);
        send(2, 8'h6E, 1, 0);  wait_idle(2);
        repeat (30) begin
            k = $urandom_range(0, 2);
            send(k, 8'($urandom), 1'($urandom), 14'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) wait_idle(k);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 3; i++) wait_idle(i);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
